// File: rtl/subtraction_unit.sv
// -----------------------------------------------------------------------------
// subtraction_unit
//   Registered subtract/compare execution unit for the ALU datapath.
//   Result and flags are computed as X + ~Y + Cin at WIDTH+1 bits. The carry
//   flag uses the "carry = NOT borrow" convention. One cycle of latency, no
//   handshake.
//
// Optional feature:
//   SUB_SAT_EN - when defined, sel=110 is SUBS, a saturating signed subtract.
//                When undefined, sel=110 behaves as NOP.
//
// Ports:
//   elk  in   clock, rising edge
//   rst  in   asynchronous active-high reset
//   opA  in   operand A (minuend)
//   opB  in   operand B (subtrahend)
//   sel  in   op select: 000 NOP, 001 SUB, 010 RSB, 011 SBC, 100 CMP,
//             101 NEG, 110 SUBS/NOP, 111 reserved (NOP)
//   res  out  registered result
//   z    out  registered zero flag
//   c    out  registered carry flag (1 = no borrow)
//   v    out  registered signed-overflow flag
// -----------------------------------------------------------------------------
module subtraction_unit #(
   parameter int WIDTH = 32
) (
   input  logic             elk,
   input  logic             rst,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] res,
   output logic             z,
   output logic             c,
   output logic             v
);

   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_RSB  = 3'b010;
   localparam logic [2:0] OP_SBC  = 3'b011;
   localparam logic [2:0] OP_CMP  = 3'b100;
   localparam logic [2:0] OP_NEG  = 3'b101;
   localparam logic [2:0] OP_SUBS = 3'b110;

   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] res_q, res_d;
   logic             z_q, z_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   // Carry fed to SBC; tracks the carry of the last flag-writing op.
   logic             cin_q, cin_d;

   logic [WIDTH-1:0] x, y;
   logic             cin;
   logic             upd_flags;
   logic             upd_res;
   logic             sat;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] diff_fin;
   logic             ovf;

   always_comb begin
      x         = opA;
      y         = opB;
      cin       = 1'b1;
      upd_flags = 1'b0;
      upd_res   = 1'b0;
      sat       = 1'b0;
      case (sel)
         OP_SUB: begin
            upd_flags = 1'b1;
            upd_res   = 1'b1;
         end
         OP_RSB: begin
            x         = opB;
            y         = opA;
            upd_flags = 1'b1;
            upd_res   = 1'b1;
         end
         OP_SBC: begin
            cin       = cin_q;
            upd_flags = 1'b1;
            upd_res   = 1'b1;
         end
         OP_CMP: begin
            upd_flags = 1'b1;
         end
         OP_NEG: begin
            x         = '0;
            y         = opA;
            upd_flags = 1'b1;
            upd_res   = 1'b1;
         end
`ifdef SUB_SAT_EN
         OP_SUBS: begin
            upd_flags = 1'b1;
            upd_res   = 1'b1;
            sat       = 1'b1;
         end
`endif
         default: ;  // NOP, reserved, and SUBS when disabled: hold everything
      endcase
   end

   // Shared subtractor: X + ~Y + Cin, with the extra bit as carry-out.
   always_comb begin
      sum  = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, cin};
      diff = sum[WIDTH-1:0];
      ovf  = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
      diff_fin = diff;
      // On signed overflow the sign of X tells the direction: a negative X
      // overflowed past the most negative value, a positive X past the max.
      if (sat && ovf)
         diff_fin = x[WIDTH-1] ? SAT_MIN : SAT_MAX;
   end

   always_comb begin
      res_d = res_q;
      z_d   = z_q;
      c_d   = c_q;
      v_d   = v_q;
      cin_d = cin_q;
      if (upd_res)
         res_d = diff_fin;
      if (upd_flags) begin
         z_d   = (diff_fin == '0);
         c_d   = sum[WIDTH];
         v_d   = ovf;
         cin_d = sum[WIDTH];
      end
   end

   always_ff @(posedge elk or posedge rst) begin
      if (rst) begin
         res_q <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
         v_q   <= 1'b0;
         cin_q <= 1'b0;
      end else begin
         res_q <= res_d;
         z_q   <= z_d;
         c_q   <= c_d;
         v_q   <= v_d;
         cin_q <= cin_d;
      end
   end

   assign res = res_q;
   assign z   = z_q;
   assign c   = c_q;
   assign v   = v_q;

endmodule

// File: tb/tb_subtraction_unit.sv
// Directed-vector bench for subtraction_unit. Build with +define+SUB_SAT_EN to
// exercise the saturating subtract; otherwise sel=110 is checked as a hold.
module tb_subtraction_unit;

   logic        elk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] opA = '0;
   logic [31:0] opB = '0;
   logic [2:0]  sel = 3'b000;
   logic [31:0] res;
   logic        z, c, v;

   int checks = 0;
   int errors = 0;

   subtraction_unit #(.WIDTH(32)) dut (
      .elk(elk), .rst(rst), .opA(opA), .opB(opB), .sel(sel),
      .res(res), .z(z), .c(c), .v(v)
   );

   always #5 elk = ~elk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] er,
                          input logic ez, input logic ec, input logic ev);
      chk({tag, ".res"}, res, er);
      chk({tag, ".z"}, {31'd0, z}, {31'd0, ez});
      chk({tag, ".c"}, {31'd0, c}, {31'd0, ec});
      chk({tag, ".v"}, {31'd0, v}, {31'd0, ev});
   endtask

   // Drive on the falling edge, then sample 1 time unit after the rising edge.
   task automatic op(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
      @(negedge elk);
      sel = s; opA = a; opB = b;
      @(posedge elk);
      #1;
   endtask

   initial begin
      // Reset state while rst is held.
      #12;
      chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge elk);
      rst = 1'b0;

      op(3'b001, 32'd7, 32'd3);
      chk_all("sub7_3", 32'd4, 1'b0, 1'b1, 1'b0);

      // Mid-cycle asynchronous reset with SUB 10-2 on the inputs.
      @(negedge elk);
      sel = 3'b001; opA = 32'd10; opB = 32'd2;
      #2 rst = 1'b1;
      #1;
      chk_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
      @(posedge elk); #1;
      chk_all("rst_over_edge", 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge elk);
      rst = 1'b0;
      @(posedge elk); #1;
      chk_all("post_rst_sub10_2", 32'd8, 1'b0, 1'b1, 1'b0);

      op(3'b001, 32'd0, 32'd0);
      chk_all("sub0_0", 32'd0, 1'b1, 1'b1, 1'b0);
      op(3'b001, 32'd2, 32'd2);
      chk_all("sub2_2", 32'd0, 1'b1, 1'b1, 1'b0);
      op(3'b001, 32'd2, 32'd10);
      chk_all("sub2_10", 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0);
      op(3'b001, 32'h8000_0000, 32'd1);
      chk_all("sub_min_1", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);

      op(3'b010, 32'd2, 32'd10);
      chk_all("rsb2_10", 32'd8, 1'b0, 1'b1, 1'b0);
      op(3'b100, 32'd5, 32'd5);
      chk_all("cmp5_5", 32'd8, 1'b1, 1'b1, 1'b0);

      // SBC chain: borrow from SUB feeds into SBC.
      op(3'b001, 32'd0, 32'd1);
      chk_all("sub0_1", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      op(3'b011, 32'd5, 32'd2);
      chk_all("sbc5_2_borrow", 32'd2, 1'b0, 1'b1, 1'b0);
      op(3'b000, 32'd7, 32'd7);
      chk_all("nop_hold", 32'd2, 1'b0, 1'b1, 1'b0);
      op(3'b111, 32'd0, 32'd0);
      chk_all("rsvd_hold", 32'd2, 1'b0, 1'b1, 1'b0);

      op(3'b101, 32'h8000_0000, 32'd0);
      chk_all("neg_min", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
      op(3'b101, 32'd0, 32'd0);
      chk_all("neg0", 32'd0, 1'b1, 1'b1, 1'b0);
      op(3'b011, 32'd5, 32'd2);
      chk_all("sbc5_2_carry", 32'd3, 1'b0, 1'b1, 1'b0);
      op(3'b101, 32'd5, 32'd0);
      chk_all("neg5", 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0);

      op(3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
`ifdef SUB_SAT_EN
      chk_all("subs_pos_sat", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
      op(3'b110, 32'h8000_0000, 32'd1);
      chk_all("subs_neg_sat", 32'h8000_0000, 1'b0, 1'b1, 1'b1);
      op(3'b110, 32'd9, 32'd4);
      chk_all("subs_nosat", 32'd5, 1'b0, 1'b1, 1'b0);
`else
      chk_all("sel110_hold", 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/subtraction_unit.md
Name: subtraction_unit

Overview:
- Registered 32-bit subtract/compare execution unit for the ALU datapath.
- Takes two operands and a 3-bit op select, and produces a 32-bit result plus Z/C/V flags.
- Outputs are registered: one cycle of latency, no handshake.
- Carry follows the "carry = NOT borrow" convention, i.e. A + ~B + 1.

Parameters:
- WIDTH, 32, operand and result width in bits; flags are computed at this width.

Ports:
- elk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- opA  input  WIDTH  operand A (minuend).
- opB  input  WIDTH  operand B (subtrahend).
- sel  input  3  operation select.
- res  output  WIDTH  registered result.
- z  output  1  registered zero flag.
- c  output  1  registered carry flag (1 = no borrow).
- v  output  1  registered signed-overflow flag.

Behaviour:
- Reset: while rst=1, asynchronously force res=0, z=0, c=0, v=0. The internal carry-in register is also cleared to 0. Reset wins over any clock edge. Deasserting reset mid-stream resumes at the next rising edge with the current inputs.
- Latency: operands and sel are sampled at a rising edge of elk. res/z/c/v reflect that operation immediately after the same edge and hold until the next edge.
- Core arithmetic: D = X + ~Y + Cin, computed at WIDTH+1 bits. c = bit WIDTH of the sum. v = (X[msb] != Y[msb]) && (D[msb] != X[msb]). z = (D == 0).
- sel=000 NOP: res, z, c and v all hold their previous values.
- sel=001 SUB: X=opA, Y=opB, Cin=1.
  - res = opA - opB mod 2^WIDTH.
  - c = 1 iff opA >= opB (unsigned).
  - 0-0 gives res=0, z=1, c=1, v=0.
- sel=010 RSB: X=opB, Y=opA, Cin=1; res = opB - opA.
- sel=011 SBC: X=opA, Y=opB, Cin = stored c from the last flag-writing op; res = opA - opB - (1 - Cin).
- sel=100 CMP: compute as SUB and update z/c/v; res holds its previous value.
- sel=101 NEG: X=0, Y=opA, Cin=1; res = -opA.
  - c=1 only when opA=0.
  - v=1 only when opA = 0x80000000.
- sel=110: see Optional Feature.
- sel=111: reserved; behaves as NOP.
- Every op except NOP and reserved updates the stored carry used by SBC.
- Wrap-around: results are modulo 2^WIDTH. Overflow is flagged only via v; there is no exception.
- opA/opB changes between edges have no effect on outputs.

Optional Feature:
- Macro SUB_SAT_EN.
- Defined: sel=110 is SUBS, a saturating signed subtract.
  - res = opA - opB, clamped to 0x7FFFFFFF when overflowing positive and to 0x80000000 when overflowing negative.
  - v = 1 when clamping occurred.
  - z is computed on the clamped res; c is as for SUB.
- Not defined: sel=110 behaves as NOP and holds all outputs.

Test Plan:
- Reset: assert rst mid-cycle with opA=10, opB=2, sel=001 -> res=0 and z=c=v=0 immediately. After release, the first edge gives res=8, z=0, c=1, v=0.
- SUB sequence, one op per edge:
  - 10-2 -> res=8, z=0, c=1, v=0.
  - 0-0 -> res=0, z=1, c=1, v=0.
  - 2-2 -> res=0, z=1, c=1, v=0.
- Borrow/overflow:
  - SUB 2-10 -> res=0xFFFFFFF8, c=0, v=0.
  - SUB 0x80000000-1 -> res=0x7FFFFFFF, c=1, v=1.
- RSB 2,10 -> res=8, c=1. CMP 5,5 -> z=1, c=1, and res unchanged from the previous value.
- SBC chain:
  - SUB 0-1 -> c=0.
  - Then SBC 5-2 -> res=2, c=1.
  - NOP next edge -> all outputs hold.
- With SUB_SAT_EN: SUBS 0x7FFFFFFF - 0xFFFFFFFF -> res=0x7FFFFFFF, v=1. Without it, sel=110 holds the outputs.
